// File: rtl/sw_cond_pkg.sv
// Shared constants and per-bit state type for the switch conditioner.
// Default debounce window is derived from the board clock and a 10 ms settle time.
package sw_cond_pkg;

  localparam int CLK_HZ                  = 100_000_000;
  localparam int DEBOUNCE_MS             = 10;
  localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } db_state_e;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: synchronizer, debounce FSM/counter and registered edge pulses; new level lands
// SYNC_STAGES + DEBOUNCE_CYCLES edges after sampling. No backpressure: free-running level input.
module debounce_bit
  import sw_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic idle
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  db_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s != clean_q) begin
          state_d = COUNT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      COUNT: begin
        if (s == clean_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Terminal count: accept the level and fire the matching edge pulse together.
          clean_d = s;
          rise_d  = s;
          fall_d  = ~s;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    clean = clean_q;
    rise  = rise_q;
    fall  = fall_q;
    idle  = (state_q == IDLE) && (s == clean_q);
  end

endmodule

// File: rtl/switch_conditioner.sv
// Debounces WIDTH raw switches into a clean code with edge pulses, settled flag and one strobe per
// settled code change; latency SYNC_STAGES + DEBOUNCE_CYCLES edges. No backpressure.
module switch_conditioner
  import sw_cond_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             settled,
  output logic             code_strobe
);

  logic [WIDTH-1:0] clean_w, rise_w, fall_w, idle_w;
  logic             settled_q, settled_d;
  logic             pending_q, pending_d;
  logic             strobe_q, strobe_d;
  logic             change_seen;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (sw_raw[i]),
      .clean(clean_w[i]),
      .rise (rise_w[i]),
      .fall (fall_w[i]),
      .idle (idle_w[i])
    );
  end

  // A change is remembered until every bit is idle, so overlapping accepts share one strobe.
  always_comb begin
    settled_d   = &idle_w;
    change_seen = pending_q | (|(rise_w | fall_w));
    strobe_d    = change_seen & settled_d;
    pending_d   = change_seen & ~settled_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settled_q <= 1'b1;
      pending_q <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      settled_q <= settled_d;
      pending_q <= pending_d;
      strobe_q  <= strobe_d;
    end
  end

  assign sw_clean    = clean_w;
  assign sw_rise     = rise_w;
  assign sw_fall     = fall_w;
  assign settled     = settled_q;
  assign code_strobe = strobe_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: directed scenarios plus randomized switch activity,
// checked every cycle against a run-length model of the debounce rules.
module tb_switch_conditioner;

  localparam int W = 4;
  localparam int S = 2;
  localparam int D = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean, sw_rise, sw_fall;
  logic         settled, code_strobe;

  switch_conditioner #(
    .WIDTH          (W),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_raw     (sw_raw),
    .sw_clean   (sw_clean),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .settled    (settled),
    .code_strobe(code_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: raw samples delayed through an S-deep history, and per bit the number of
  // consecutive cycles the synchronized level has disagreed with the accepted level.
  logic [W-1:0] m_sh [S];
  int           m_run [W];
  logic [W-1:0] m_clean, m_rise, m_fall;
  logic         m_settled, m_strobe, m_pending;
  logic [W-1:0] m_s;
  logic         m_all_idle, m_any_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < S; k++) m_sh[k] = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      m_clean = '0; m_rise = '0; m_fall = '0;
      m_settled = 1'b1; m_strobe = 1'b0; m_pending = 1'b0;
    end else begin
      m_s = m_sh[S-1];
      m_all_idle = 1'b1;
      m_any_acc  = 1'b0;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++)
        if (m_s[i] != m_clean[i] || m_run[i] != 0) m_all_idle = 1'b0;
      for (int i = 0; i < W; i++) begin
        if (m_s[i] != m_clean[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_run[i]   = 0;
            m_clean[i] = m_s[i];
            if (m_s[i]) m_rise[i] = 1'b1;
            else        m_fall[i] = 1'b1;
            m_any_acc = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_strobe  = m_all_idle && m_pending;
      if (m_strobe)  m_pending = 1'b0;
      if (m_any_acc) m_pending = 1'b1;
      m_settled = m_all_idle;
      for (int k = S - 1; k > 0; k--) m_sh[k] = m_sh[k-1];
      m_sh[0] = sw_raw;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model sw_clean", sw_clean, m_clean);
      chk("model sw_rise", sw_rise, m_rise);
      chk("model sw_fall", sw_fall, m_fall);
      chk("model settled", settled, m_settled);
      chk("model code_strobe", code_strobe, m_strobe);
      chk("rise_fall_overlap", sw_rise & sw_fall, 0);
    end
  end

  // Event counters over a window of ticks, for the directed expectations.
  int           n_rise, n_fall, n_strobe;
  logic [W-1:0] mask_rise, mask_fall, clean_or;

  task automatic clear_counts();
    n_rise = 0; n_fall = 0; n_strobe = 0;
    mask_rise = '0; mask_fall = '0; clean_or = '0;
  endtask

  task automatic tick(input logic [W-1:0] v);
    @(negedge clk);
    sw_raw = v;
    @(posedge clk);
    #1;
    if (sw_rise != 0) begin n_rise++; mask_rise |= sw_rise; end
    if (sw_fall != 0) begin n_fall++; mask_fall |= sw_fall; end
    if (code_strobe) n_strobe++;
    clean_or |= sw_clean;
  endtask

  int           hold [W];
  logic [W-1:0] rv;

  initial begin
    rst_n  = 1'b0;
    sw_raw = '0;
    clear_counts();

    // Reset state and a quiet stretch after release.
    repeat (3) @(posedge clk);
    #1;
    chk("reset sw_clean", sw_clean, 0);
    chk("reset settled", settled, 1);
    chk("reset pulses", {sw_rise, sw_fall, code_strobe}, 0);
    chk_en = 1;
    @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    repeat (20) tick(4'b0000);
    chk("quiet rise", n_rise, 0);
    chk("quiet fall", n_fall, 0);
    chk("quiet strobe", n_strobe, 0);
    chk("quiet settled", settled, 1);

    // Single bit rise: clean appears on edge 6 counted from the sampling edge.
    clear_counts();
    repeat (5) tick(4'b0001);
    chk("t2 clean before", sw_clean, 4'b0000);
    chk("t2 settled counting", settled, 0);
    tick(4'b0001);
    chk("t2 clean edge6", sw_clean, 4'b0001);
    chk("t2 rise", sw_rise, 4'b0001);
    chk("t2 strobe early", code_strobe, 0);
    tick(4'b0001);
    chk("t2 settled back", settled, 1);
    chk("t2 strobe", code_strobe, 1);
    chk("t2 rise gone", sw_rise, 0);
    tick(4'b0001);
    chk("t2 strobe one", code_strobe, 0);
    clear_counts();
    repeat (12) tick(4'b0000);
    chk("t2 release fall", mask_fall, 4'b0001);
    chk("t2 release strobe", n_strobe, 1);

    // Fast chatter on bit 0 is rejected.
    clear_counts();
    for (int j = 0; j < 20; j++) tick(((j / 2) % 2 == 0) ? 4'b0001 : 4'b0000);
    repeat (10) tick(4'b0000);
    chk("t3 clean", clean_or, 0);
    chk("t3 pulses", n_rise + n_fall + n_strobe, 0);
    chk("t3 settled", settled, 1);

    // 3-cycle pulse rejected; 4-cycle pulse accepted then released.
    clear_counts();
    repeat (3) tick(4'b0010);
    repeat (10) tick(4'b0000);
    chk("t4 short clean", clean_or, 0);
    chk("t4 short pulses", n_rise + n_fall + n_strobe, 0);
    clear_counts();
    repeat (4) tick(4'b0010);
    repeat (14) tick(4'b0000);
    chk("t4 long clean seen", clean_or, 4'b0010);
    chk("t4 rise count", n_rise, 1);
    chk("t4 rise mask", mask_rise, 4'b0010);
    chk("t4 fall count", n_fall, 1);
    chk("t4 fall mask", mask_fall, 4'b0010);
    chk("t4 strobe", n_strobe, 1);
    chk("t4 clean end", sw_clean, 0);

    // Two bits accepted together.
    clear_counts();
    repeat (12) tick(4'b1001);
    chk("t5 clean", sw_clean, 4'b1001);
    chk("t5 rise count", n_rise, 1);
    chk("t5 rise mask", mask_rise, 4'b1001);
    chk("t5 strobe", n_strobe, 1);

    // Asynchronous reset while bit 2 is mid-count.
    repeat (4) tick(4'b1101);
    chk("t6 pre clean", sw_clean, 4'b1001);
    chk("t6 pre settled", settled, 0);
    #2;
    rst_n  = 1'b0;
    sw_raw = 4'b0100;
    #1;
    chk("t6 async clean", sw_clean, 0);
    chk("t6 async settled", settled, 1);
    chk("t6 async pulses", {sw_rise, sw_fall, code_strobe}, 0);
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    clear_counts();
    repeat (5) tick(4'b0100);
    chk("t6 clean before", sw_clean, 0);
    tick(4'b0100);
    chk("t6 clean edge6", sw_clean, 4'b0100);
    chk("t6 rise", sw_rise, 4'b0100);
    tick(4'b0100);
    chk("t6 strobe", code_strobe, 1);

    // Random switch activity with occasional mid-cycle resets.
    rv = sw_raw;
    for (int i = 0; i < W; i++) hold[i] = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < W; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          rv[i]   = 1'($urandom_range(0, 1));
          hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 14))
                                                : int'($urandom_range(1, 5));
        end
      end
      tick(rv);
      if (c == 900 || c == 2100) begin
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
      end
    end
    repeat (20) tick(rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
